// File: rtl/alu_op_sequencer.sv
// Issue side of the ALU: latches one op, holds ALU inputs for a settle window, captures LO/HI.
// Result valid S edges after accept (rejects after 1); out_ready low holds DONE and blocks new requests.
module alu_op_sequencer #(
  parameter int SETTLE_SIMPLE = 1,
  parameter int SETTLE_MULDIV = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cntrl,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_cntrl,
  input  logic [31:0] alu_c_lo,
  input  logic [31:0] alu_c_hi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_lo,
  output logic [31:0] out_hi,
  output logic        out_err
);

  localparam int MAXS = (SETTLE_MULDIV > SETTLE_SIMPLE) ? SETTLE_MULDIV : SETTLE_SIMPLE;
  localparam int CW   = (MAXS < 2) ? 1 : $clog2(MAXS + 1);

  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [3:0]    cntrl_q, cntrl_d;
  logic [31:0]   lo_q, lo_d, hi_q, hi_d;
  logic          err_q, err_d;
  logic          rej_q, rej_d;
  logic          in_reject;
  logic          in_muldiv;

  assign in_reject = (in_cntrl > OP_DIV) || ((in_cntrl == OP_DIV) && (in_b == 32'd0));
  assign in_muldiv = (in_cntrl == OP_MUL) || (in_cntrl == OP_DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cntrl_d = cntrl_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    rej_d   = rej_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cntrl_d = in_cntrl;
          state_d = EXEC;
          rej_d   = in_reject;
          // Rejected ops spend a single EXEC cycle with capture suppressed.
          if (in_reject)      cnt_d = CW'(1);
          else if (in_muldiv) cnt_d = CW'(SETTLE_MULDIV);
          else                cnt_d = CW'(SETTLE_SIMPLE);
        end
      end
      EXEC: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (rej_q) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            lo_d  = alu_c_lo;
            if ((cntrl_q == OP_MUL) || (cntrl_q == OP_DIV)) hi_d = alu_c_hi;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cntrl_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cntrl_q <= cntrl_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      rej_q   <= rej_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_cntrl = cntrl_q;
  assign out_lo    = lo_q;
  assign out_hi    = hi_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU closing the loop.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cntrl;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_cntrl;
  logic [31:0] alu_c_lo, alu_c_hi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_lo, out_hi;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_SIMPLE(1), .SETTLE_MULDIV(4)) dut (
    .clk(clk), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cntrl(in_cntrl), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_c_lo(alu_c_lo), .alu_c_hi(alu_c_hi),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lo(out_lo), .out_hi(out_hi), .out_err(out_err)
  );

  // ALU model: MUL packs the 64-bit product as {HI,LO}; DIV gives LO=quotient, HI=remainder.
  logic [63:0] prod;
  always_comb begin
    prod     = {32'd0, alu_a} * {32'd0, alu_b};
    alu_c_lo = 32'd0;
    alu_c_hi = 32'd0;
    case (alu_cntrl)
      4'd0: alu_c_lo = alu_a & alu_b;
      4'd1: alu_c_lo = alu_a | alu_b;
      4'd2: alu_c_lo = alu_a + alu_b;
      4'd3: alu_c_lo = alu_a - alu_b;
      4'd4: alu_c_lo = -alu_a;
      4'd5: alu_c_lo = ~alu_a;
      4'd10: begin
        alu_c_lo = prod[31:0];
        alu_c_hi = prod[63:32];
      end
      4'd11: begin
        if (alu_b != 32'd0) begin
          alu_c_lo = alu_a / alu_b;
          alu_c_hi = alu_a % alu_b;
        end
      end
      default: alu_c_lo = 32'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE; returns just after the accepting edge (edge 0).
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_cntrl = c;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges after accept until out_valid is seen; -1 if it never comes.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    if (!out_valid) cycles = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_lo !== 32'd0 || out_hi !== 32'd0) begin bad++; $display("FAIL reset_lohi got=%h/%h want=0/0", out_hi, out_lo); end
    total++; if (out_err !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b want=0", out_err); end
    total++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_cntrl !== 4'd0) begin bad++; $display("FAIL reset_alu got=%h %h %h want=0", alu_a, alu_b, alu_cntrl); end
  endtask

  task automatic test_add();
    int cyc;
    issue(4'd2, 32'd5, 32'd7);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_busy in_ready got=%b want=0", in_ready); end
    total++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_cntrl !== 4'd2) begin bad++; $display("FAIL add_alu_latch got=%h %h %h want=5 7 2", alu_a, alu_b, alu_cntrl); end
    wait_done(cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL add_latency got=%0d want=1", cyc); end
    total++; if (out_lo !== 32'd12 || out_hi !== 32'd0 || out_err !== 1'b0) begin bad++; $display("FAIL add_result got lo=%h hi=%h err=%b want 0000000c 0 0", out_lo, out_hi, out_err); end
    drain();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL add_handshake got v=%b r=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_mul_div_zero_or();
    int cyc;
    issue(4'd10, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL mul_latency got=%0d want=4", cyc); end
    total++; if (out_lo !== 32'd0 || out_hi !== 32'd1 || out_err !== 1'b0) begin bad++; $display("FAIL mul_result got lo=%h hi=%h err=%b want 0 1 0", out_lo, out_hi, out_err); end
    drain();
    issue(4'd11, 32'd7, 32'd0);
    wait_done(cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL divz_latency got=%0d want=1", cyc); end
    total++; if (out_err !== 1'b1 || out_lo !== 32'd0 || out_hi !== 32'd1) begin bad++; $display("FAIL divz_result got lo=%h hi=%h err=%b want 0 1 1", out_lo, out_hi, out_err); end
    drain();
    issue(4'd1, 32'h0000_00F0, 32'h0000_000F);
    wait_done(cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL or_latency got=%0d want=1", cyc); end
    total++; if (out_lo !== 32'h0000_00FF || out_hi !== 32'd1 || out_err !== 1'b0) begin bad++; $display("FAIL or_result got lo=%h hi=%h err=%b want ff 1 0", out_lo, out_hi, out_err); end
    drain();
  endtask

  task automatic test_illegal_then_div();
    int cyc;
    issue(4'd13, 32'd1, 32'd2);
    wait_done(cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL ill_latency got=%0d want=1", cyc); end
    total++; if (out_err !== 1'b1 || out_lo !== 32'h0000_00FF || out_hi !== 32'd1) begin bad++; $display("FAIL ill_result got lo=%h hi=%h err=%b want ff 1 1", out_lo, out_hi, out_err); end
    drain();
    issue(4'd11, 32'd17, 32'd5);
    wait_done(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL div_latency got=%0d want=4", cyc); end
    total++; if (out_err !== 1'b0 || out_lo !== 32'd3 || out_hi !== 32'd2) begin bad++; $display("FAIL div_result got lo=%h hi=%h err=%b want 3 2 0", out_lo, out_hi, out_err); end
    drain();
  endtask

  task automatic test_backpressure();
    int cyc;
    issue(4'd3, 32'd3, 32'd5);
    wait_done(cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL sub_latency got=%0d want=1", cyc); end
    // A competing request must be ignored while the result is held.
    in_valid = 1'b1;
    in_cntrl = 4'd0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL bp_hold[%0d] got v=%b r=%b lo=%h want 1 0 fffffffe", i, out_valid, in_ready, out_lo); end
      tick();
    end
    total++; if (alu_cntrl !== 4'd3 || alu_a !== 32'd3) begin bad++; $display("FAIL bp_no_accept got cntrl=%h a=%h want 3 3", alu_cntrl, alu_a); end
    in_valid = 1'b0;
    drain();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL bp_release got v=%b r=%b lo=%h want 0 1 fffffffe", out_valid, in_ready, out_lo); end
  endtask

  task automatic test_clear_mid_exec();
    issue(4'd10, 32'h0001_0000, 32'h0003_0000);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL clr_flags got v=%b r=%b want 0 1", out_valid, in_ready); end
    total++; if (out_lo !== 32'd0 || out_hi !== 32'd0 || out_err !== 1'b0) begin bad++; $display("FAIL clr_regs got lo=%h hi=%h err=%b want 0 0 0", out_lo, out_hi, out_err); end
    total++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_cntrl !== 4'd0) begin bad++; $display("FAIL clr_alu got %h %h %h want 0", alu_a, alu_b, alu_cntrl); end
    repeat (4) tick();
    total++; if (out_valid !== 1'b0 || out_lo !== 32'd0 || out_hi !== 32'd0) begin bad++; $display("FAIL clr_no_late_capture got v=%b lo=%h hi=%h want 0 0 0", out_valid, out_lo, out_hi); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    wait_done(cyc);
    drain();
    issue(4'd5, 32'h0000_FFFF, 32'd0);
    wait_done(cyc);
    total++; if (cyc != 1 || out_lo !== 32'hFFFF_0000 || out_hi !== 32'd0) begin bad++; $display("FAIL b2b_not got cyc=%0d lo=%h hi=%h want 1 ffff0000 0", cyc, out_lo, out_hi); end
    drain();
  endtask

  initial begin
    clear     = 1'b1;
    in_valid  = 1'b0;
    in_cntrl  = 4'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_mul_div_zero_or();
    test_illegal_then_div();
    test_backpressure();
    test_clear_mid_exec();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
